vga_sync_decoder: RTL
=====================

// Module: vga_sync_decoder
// PURPOSE
//  Receive-side counterpart of the VGA output chain: takes hsync/vsync/rgb as
//  driven to the pins and recovers hcount/vcount/blanking, lock and timing-error
//  status. Used as an on-chip loopback checker and as the bench's frame-capture
//  front end. Timing is 1024x768@60, pclk 65 MHz.
// PARAMETERS
//  H_TOTAL      1344  pixels per line
//  H_VISIBLE    1024  active pixels per line
//  H_SYNC_START 1048  hcount of the first hsync-active pixel
//  V_TOTAL      806   lines per frame
//  V_VISIBLE    768   active lines
//  V_SYNC_START 771   vcount of the first vsync-active line
//  SYNC_POL     1     1 = syncs active-high, 0 = active-low
//  LOCK_LINES   4     consecutive correctly spaced hsync edges needed for h-lock
// PORTS
//  pclk         in   1   pixel clock
//  rst          in   1   asynchronous reset, active-high
//  hsync_in     in   1   horizontal sync from the generator chain
//  vsync_in     in   1   vertical sync
//  rgb_in       in   12  pixel colour {r,g,b}
//  hcount_out   out  11  recovered pixel column
//  vcount_out   out  11  recovered line
//  hblnk_out    out  1   hcount_out >= H_VISIBLE
//  vblnk_out    out  1   vcount_out >= V_VISIBLE
//  rgb_out      out  12  rgb_in aligned to counters; 0 when pixel_valid=0
//  pixel_valid  out  1   locked & !hblnk_out & !vblnk_out
//  frame_start  out  1   1-cycle pulse when (hcount_out,vcount_out)=(0,0) while locked
//  locked       out  1   FSM in LOCKED
//  h_err        out  1   1-cycle pulse: hsync edge misplaced or missing (after h-lock)
//  v_err        out  1   1-cycle pulse: vsync edge misplaced or missing (LOCKED only)
//  err_cnt      out  8   saturating count of h_err|v_err pulses; cleared only by rst
// BEHAVIOUR
//  Reset: all outputs 0; FSM=SEARCH; counters 0; edge-detect history = inactive.
//  Input path: hs/vs/rgb registered twice (s1,s2); leading edge = s1 active & s2
//   not (polarity per SYNC_POL). Outputs are registered from s1-stage decisions:
//   fixed latency 3 pclk from input pin sample to outputs.
//  H counter: hcount free-runs 0..H_TOTAL-1 and wraps. On an hsync leading edge,
//   the sample is assigned hcount=H_SYNC_START (counter forced). Predicted position
//   = free-run value before forcing.
//  V counter: increments when hcount wraps H_TOTAL-1->0; wraps V_TOTAL-1->0. On a
//   vsync leading edge, the line is forced to vcount=V_SYNC_START.
//  Both edges on the same sample: both forces apply; no priority issue.
//  FSM:
//   SEARCH: locked=0, no err pulses. Count hsync edges whose predicted hcount ==
//    H_SYNC_START; a mismatch clears the count to 1. At LOCK_LINES -> HLOCK.
//   HLOCK: h_err active. Misplaced/missing hsync -> SEARCH. The first vsync edge
//    only forces vcount; the next vsync edge with predicted vcount==V_SYNC_START
//    (and hcount aligned) -> LOCKED; a mismatched vsync edge restarts this wait.
//   LOCKED: locked=1. Misplaced/missing hsync -> h_err, -> SEARCH. Misplaced vsync
//    or no vsync edge when vcount reaches V_SYNC_START -> v_err, -> HLOCK.
//  Missing edge: predicted hcount==H_SYNC_START with no leading edge on that sample.
//  Timeout: no hsync edge for 2*H_TOTAL cycles in any state -> SEARCH, count=0.
//  err_cnt saturates at 255; h_err and v_err on the same cycle count as one.
//  rgb_out = 0 whenever pixel_valid=0; counters keep running in SEARCH.
// STRUCTURE
//  Timing constants go in a shared header vga_timing_params.vh, also used by
//   vga_timing, so generator and decoder cannot diverge.
//  FSM state encodings are localparams in this file.
//  One sub-module: sync_edge_det (2-FF register + polarity + leading-edge pulse),
//   instantiated for hsync and vsync.
// TESTING
//  1 Drive from vga_timing (rst released) -> locked=1 within 2 frames; then
//    hcount_out/vcount_out match generator counters delayed 3 pclk, every cycle,
//    for 3 frames.
//  2 Locked; one hsync edge late by 1 pixel on line 100 -> one h_err, locked=0,
//    err_cnt=1; relock within 2 frames.
//  3 Locked; suppress one vsync pulse -> v_err when vcount hits 771, FSM in HLOCK,
//    locked=1 again after 2 more good frames; err_cnt=1.
//  4 Hold hsync inactive 3000 cycles -> SEARCH, locked=0, no extra h_err beyond the
//    first missing-edge pulse.
//  5 Assert rst mid-frame (vcount~400) -> all outputs 0 at once; after release,
//    relock within 2 frames.
//  6 rgb_in=12'hF00 everywhere -> rgb_out=F00 only when pixel_valid;
//    frame_start once per 1344*806 cycles.

Source files
------------

// File: rtl/vga_sync_decoder_pkg.sv
// Shared definitions for the VGA sync decoder: 1024x768@60 timing constants
// (the same numbers the vga_timing generator uses), decoder state encoding and
// a small wrapping-counter helper.
package vga_sync_decoder_pkg;

    // 1024x768@60, 65 MHz pixel clock
    localparam int VGA_H_TOTAL      = 1344;
    localparam int VGA_H_VISIBLE    = 1024;
    localparam int VGA_H_SYNC_START = 1048;
    localparam int VGA_V_TOTAL      = 806;
    localparam int VGA_V_VISIBLE    = 768;
    localparam int VGA_V_SYNC_START = 771;
    localparam int VGA_SYNC_POL     = 1;
    localparam int VGA_LOCK_LINES   = 4;

    localparam int CNT_W  = 11;
    localparam int TMO_W  = 12;
    localparam int LCNT_W = 4;

    localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_HLOCK  = 2'd1,
        ST_LOCKED = 2'd2
    } dec_state_e;

    // Increment a position counter, wrapping to zero after the last value.
    function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] val,
                                                  input logic [CNT_W-1:0] last);
        logic [CNT_W-1:0] res;
        if (val == last) begin
            res = 11'd0;
        end else begin
            res = val + 11'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/vga_sync_decoder_edge.sv
// Two-flop sync register with polarity normalisation and leading-edge pulse.
// History resets to the inactive level so a sync already active at reset
// release still produces an edge.
module sync_edge_det #(
    parameter logic SYNC_POL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_in,
    output logic lead_edge
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    // Normalise to active-high and shift the sample history.
    always_comb begin
        s1_d = SYNC_POL ? sync_in : ~sync_in;
        s2_d = s1_q;
    end

    // Sample history registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign lead_edge = s1_q & ~s2_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA decoder: recovers pixel/line counters from hsync/vsync,
// tracks lock, flags misplaced or missing sync edges and re-times rgb to the
// recovered counters. Decisions are taken on the s1 sample; outputs appear a
// fixed 3 pclk after the pin sample.
module vga_sync_decoder
    import vga_sync_decoder_pkg::*;
#(
    parameter int H_TOTAL      = VGA_H_TOTAL,
    parameter int H_VISIBLE    = VGA_H_VISIBLE,
    parameter int H_SYNC_START = VGA_H_SYNC_START,
    parameter int V_TOTAL      = VGA_V_TOTAL,
    parameter int V_VISIBLE    = VGA_V_VISIBLE,
    parameter int V_SYNC_START = VGA_V_SYNC_START,
    parameter int SYNC_POL     = VGA_SYNC_POL,
    parameter int LOCK_LINES   = VGA_LOCK_LINES
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [11:0] rgb_in,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic        pixel_valid,
    output logic        frame_start,
    output logic        locked,
    output logic        h_err,
    output logic        v_err,
    output logic [7:0]  err_cnt
);

    localparam logic [CNT_W-1:0]  H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0]  H_SYNC    = CNT_W'(H_SYNC_START);
    localparam logic [CNT_W-1:0]  H_VIS     = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0]  V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0]  V_SYNC    = CNT_W'(V_SYNC_START);
    localparam logic [CNT_W-1:0]  V_VIS     = CNT_W'(V_VISIBLE);
    localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(2 * H_TOTAL);
    localparam logic [LCNT_W-1:0] LOCK_LAST = LCNT_W'(LOCK_LINES - 1);

    // s1-stage edge pulses
    logic hs_edge_s, vs_edge_s;

    // decision-stage state (describes the sample now in s2)
    logic [CNT_W-1:0]  hcnt_q, hcnt_d;
    logic [CNT_W-1:0]  vcnt_q, vcnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [LCNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic              v_seen_q, v_seen_d;
    dec_state_e        state_q, state_d, state_nx_s;
    logic              h_err_a_q, h_err_a_d;
    logic              v_err_a_q, v_err_a_d;
    logic [11:0]       rgb_s1_q, rgb_s1_d;
    logic [11:0]       rgb_s2_q, rgb_s2_d;

    // output stage
    logic [CNT_W-1:0] hcount_out_q, hcount_out_d;
    logic [CNT_W-1:0] vcount_out_q, vcount_out_d;
    logic             hblnk_q, hblnk_d;
    logic             vblnk_q, vblnk_d;
    logic [11:0]      rgb_out_q, rgb_out_d;
    logic             pixel_valid_q, pixel_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             locked_q, locked_d;
    logic             h_err_q, h_err_d;
    logic             v_err_q, v_err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    // prediction / classification helpers
    logic             h_wrap_s;
    logic [CNT_W-1:0] pred_h_s, pred_v_s;
    logic             h_at_sync_s, v_at_sync_s;
    logic             h_bad_s, v_bad_s;
    logic             timeout_s;
    logic             locked_a_s;

    sync_edge_det #(.SYNC_POL(SYNC_POL != 0)) u_hs_det (
        .clk       (pclk),
        .rst       (rst),
        .sync_in   (hsync_in),
        .lead_edge (hs_edge_s)
    );

    sync_edge_det #(.SYNC_POL(SYNC_POL != 0)) u_vs_det (
        .clk       (pclk),
        .rst       (rst),
        .sync_in   (vsync_in),
        .lead_edge (vs_edge_s)
    );

    // Free-run prediction, forcing on sync edges, and edge classification.
    always_comb begin
        h_wrap_s = (hcnt_q == H_LAST);
        pred_h_s = wrap_inc(hcnt_q, H_LAST);
        if (h_wrap_s) begin
            pred_v_s = wrap_inc(vcnt_q, V_LAST);
        end else begin
            pred_v_s = vcnt_q;
        end
        if (hs_edge_s) begin
            hcnt_d = H_SYNC;
        end else begin
            hcnt_d = pred_h_s;
        end
        if (vs_edge_s) begin
            vcnt_d = V_SYNC;
        end else begin
            vcnt_d = pred_v_s;
        end
        // vsync is expected to rise at the start of line V_SYNC_START
        h_at_sync_s = (pred_h_s == H_SYNC);
        v_at_sync_s = (pred_v_s == V_SYNC) && (pred_h_s == 11'd0);
        // misplaced edge or missing edge at the predicted position
        h_bad_s     = hs_edge_s ^ h_at_sync_s;
        v_bad_s     = vs_edge_s ^ v_at_sync_s;
        rgb_s1_d    = rgb_in;
        rgb_s2_d    = rgb_s1_q;
    end

    // hsync watchdog: fires once after 2*H_TOTAL samples without an edge.
    always_comb begin
        if (hs_edge_s) begin
            tmo_d     = 12'd0;
            timeout_s = 1'b0;
        end else if (tmo_q >= TMO_LIMIT) begin
            tmo_d     = tmo_q;
            timeout_s = 1'b0;
        end else begin
            tmo_d     = tmo_q + 12'd1;
            timeout_s = (tmo_q == (TMO_LIMIT - 12'd1));
        end
    end

    // Lock FSM next-state and error pulse generation.
    always_comb begin
        state_nx_s = state_q;
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        v_seen_d   = v_seen_q;
        h_err_a_d  = 1'b0;
        v_err_a_d  = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                if (hs_edge_s) begin
                    if (!h_at_sync_s) begin
                        lock_cnt_d = 4'd1;
                    end else if (lock_cnt_q >= LOCK_LAST) begin
                        state_nx_s = ST_HLOCK;
                        lock_cnt_d = 4'd0;
                        v_seen_d   = 1'b0;
                    end else begin
                        lock_cnt_d = lock_cnt_q + 4'd1;
                    end
                end else if (h_at_sync_s) begin
                    lock_cnt_d = 4'd0;
                end else begin
                    lock_cnt_d = lock_cnt_q;
                end
            end
            ST_HLOCK: begin
                if (h_bad_s) begin
                    h_err_a_d  = 1'b1;
                    state_nx_s = ST_SEARCH;
                    lock_cnt_d = hs_edge_s ? 4'd1 : 4'd0;
                end else if (vs_edge_s) begin
                    // first edge only aligns vcount; a second matching one confirms it
                    if (v_seen_q && v_at_sync_s) begin
                        state_nx_s = ST_LOCKED;
                    end else begin
                        v_seen_d = 1'b1;
                    end
                end else begin
                    v_seen_d = v_seen_q;
                end
            end
            ST_LOCKED: begin
                if (h_bad_s) begin
                    h_err_a_d  = 1'b1;
                    state_nx_s = ST_SEARCH;
                    lock_cnt_d = hs_edge_s ? 4'd1 : 4'd0;
                end else if (v_bad_s) begin
                    v_err_a_d  = 1'b1;
                    state_nx_s = ST_HLOCK;
                    v_seen_d   = 1'b0;
                end else begin
                    state_nx_s = ST_LOCKED;
                end
            end
            default: begin
                state_nx_s = ST_SEARCH;
                lock_cnt_d = 4'd0;
                v_seen_d   = 1'b0;
            end
        endcase
        if (timeout_s) begin
            state_d    = ST_SEARCH;
            lock_cnt_d = 4'd0;
        end else begin
            state_d = state_nx_s;
        end
    end

    // Output stage: blanking, gated rgb, frame marker and error counter.
    always_comb begin
        locked_a_s    = (state_q == ST_LOCKED);
        hcount_out_d  = hcnt_q;
        vcount_out_d  = vcnt_q;
        hblnk_d       = (hcnt_q >= H_VIS);
        vblnk_d       = (vcnt_q >= V_VIS);
        pixel_valid_d = locked_a_s & ~hblnk_d & ~vblnk_d;
        if (pixel_valid_d) begin
            rgb_out_d = rgb_s2_q;
        end else begin
            rgb_out_d = 12'h000;
        end
        frame_start_d = locked_a_s && (hcnt_q == 11'd0) && (vcnt_q == 11'd0);
        locked_d      = locked_a_s;
        h_err_d       = h_err_a_q;
        v_err_d       = v_err_a_q;
        // simultaneous h and v errors count once
        if ((h_err_a_q || v_err_a_q) && (err_cnt_q != ERR_CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Decision-stage registers.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            hcnt_q     <= 11'd0;
            vcnt_q     <= 11'd0;
            tmo_q      <= 12'd0;
            lock_cnt_q <= 4'd0;
            v_seen_q   <= 1'b0;
            state_q    <= ST_SEARCH;
            h_err_a_q  <= 1'b0;
            v_err_a_q  <= 1'b0;
            rgb_s1_q   <= 12'h000;
            rgb_s2_q   <= 12'h000;
        end else begin
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            tmo_q      <= tmo_d;
            lock_cnt_q <= lock_cnt_d;
            v_seen_q   <= v_seen_d;
            state_q    <= state_d;
            h_err_a_q  <= h_err_a_d;
            v_err_a_q  <= v_err_a_d;
            rgb_s1_q   <= rgb_s1_d;
            rgb_s2_q   <= rgb_s2_d;
        end
    end

    // Output registers.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            hcount_out_q  <= 11'd0;
            vcount_out_q  <= 11'd0;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            rgb_out_q     <= 12'h000;
            pixel_valid_q <= 1'b0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            h_err_q       <= 1'b0;
            v_err_q       <= 1'b0;
            err_cnt_q     <= 8'd0;
        end else begin
            hcount_out_q  <= hcount_out_d;
            vcount_out_q  <= vcount_out_d;
            hblnk_q       <= hblnk_d;
            vblnk_q       <= vblnk_d;
            rgb_out_q     <= rgb_out_d;
            pixel_valid_q <= pixel_valid_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
            h_err_q       <= h_err_d;
            v_err_q       <= v_err_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign hcount_out  = hcount_out_q;
    assign vcount_out  = vcount_out_q;
    assign hblnk_out   = hblnk_q;
    assign vblnk_out   = vblnk_q;
    assign rgb_out     = rgb_out_q;
    assign pixel_valid = pixel_valid_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign h_err       = h_err_q;
    assign v_err       = v_err_q;
    assign err_cnt     = err_cnt_q;

endmodule
